mac_operand_streamer: RTL and testbench
=======================================

# mac_operand_streamer

- Feeds one convolution window at a time into the MAC operand port and collects the MAC result.
- On a start command it:
  - reads a KERNEL_SIZE×KERNEL_SIZE patch of the input feature map and the matching kernel weights from two synchronous-read memories;
  - streams them as a contiguous valid burst, then terminates the burst with the kernel bias;
  - captures the single accumulated result and presents it downstream on a valid/ready port.
- Sits between the feature-map/weight buffers and one MAC instance in the convolution layer datapath.

## Interface
Parameters:
- INPUT_BIT_RESOLUTION, 8, operand width (signed two's complement)
- OUTPUT_BIT_RESOLUTION, 32, accumulator/bias/result width
- KERNEL_SIZE, 3, window edge length
- FIN_WIDTH, 28, feature-map row length in pixels
- ADDR_WIDTH, 10, memory address width

Ports:
- Clock and reset: one clock `clk_i`; reset is asynchronous and active-high, named `rst_i`.
  - clk_i  in  1  clock
  - rst_i  in  1  asynchronous active-high reset
- Command:
  - start_i  in  1  one-cycle start pulse; ignored unless idle
  - win_row_i, win_col_i  in  ADDR_WIDTH  window top-left pixel, sampled on accepted start
  - busy_o  out  1  high from accepted start until result handshake completes
  - err_o  out  1  sticky result-timeout flag, cleared by next accepted start
- Feature-map memory:
  - fin_addr_o  out  ADDR_WIDTH
  - fin_en_o  out  1
  - fin_rdata_i  in  INPUT_BIT_RESOLUTION; 1-cycle read latency
- Kernel memory:
  - ker_addr_o  out  ADDR_WIDTH
  - ker_en_o  out  1
  - ker_rdata_i  in  INPUT_BIT_RESOLUTION; 1-cycle read latency
- Bias:
  - bias_i  in  OUTPUT_BIT_RESOLUTION  kernel bias, sampled on accepted start
- MAC side:
  - mac_fin_and_kernel_valid_o  out  1
  - mac_fin_data_o, mac_kernel_data_o  out  INPUT_BIT_RESOLUTION
  - mac_kernel_bias_o  out  OUTPUT_BIT_RESOLUTION
  - mac_valid_i  in  1
  - mac_data_i  in  OUTPUT_BIT_RESOLUTION
  - mac_ready_o  out  1
- Result:
  - res_valid_o  out  1
  - res_data_o  out  OUTPUT_BIT_RESOLUTION
  - res_ready_i  in  1

## Operation
- FSM states: IDLE, PRIME, FETCH, DRAIN, TERM, WAIT_RES, OUT. Reset enters IDLE with every output 0.
- IDLE: on start_i, go to PRIME. The accepted start:
  - latches the window origin and bias_i;
  - clears err_o;
  - clears the row counter i and column counter j.
- PRIME: one beat with valid=1 and both operands=0; the MAC discards the first beat of every burst. Memory reads of element (0,0) issue in this cycle.
- FETCH: issues K² read pairs, one per cycle, with j inner and i outer.
  - fin_addr = (win_row+i)*FIN_WIDTH + win_col + j
  - ker_addr = i*KERNEL_SIZE + j
  - Addresses come from incremental counters; no multiplier on the address path beyond a row-stride accumulator.
  - Addresses wrap modulo 2^ADDR_WIDTH; windows crossing the map edge are the caller's responsibility.
- Operand registers load the memory read data the cycle after each read, so valid stays high continuously for exactly 1+K² cycles.
- DRAIN: one cycle that lets the last read data reach the operand registers.
- TERM: valid=0 and operands=0, with mac_kernel_bias_o = latched bias. Bias holds this value in every state from PRIME to WAIT_RES.
- WAIT_RES:
  - mac_ready_o=1 from TERM through WAIT_RES.
  - On mac_valid_i, register mac_data_i into the result buffer and go to OUT.
  - If no mac_valid_i within 4 cycles of entering WAIT_RES: set err_o, load the result as all-ones, go to OUT.
- OUT: res_valid_o=1 and res_data_o held stable until res_ready_i. On the handshake cycle, go to IDLE and drop busy_o.
- Arithmetic: the block does no accumulation; it only forwards. Operands pass through bit-exact as signed values.
- start_i while busy: ignored with no side effect.
- rst_i at any time (including mid-burst): immediately aborts, drops valid, and returns to IDLE. The MAC is reset by the same reset.

## Timing
- Accepted start at cycle 0:
  - PRIME at cycle 1.
  - Valid high on cycles 1..1+K²; operand data for element n appears at cycle 2+n.
  - TERM (valid low) at cycle 2+K².
  - Earliest mac_valid_i at cycle 3+K².
  - res_valid_o at cycle 4+K².
- For K=3: res_valid_o at cycle 13.
- Back-to-back throughput: one window per 5+K² cycles when res_ready_i is held high. The next start is accepted the cycle after the result handshake.
- res_valid_o is not retracted before the handshake.

## Configuration
- Macro: MAC_OPERAND_STREAMER_RELU_EN.
  - Defined: negative results (MSB=1) are replaced by 0 when loaded into the result buffer. The timeout value is exempt from this.
  - Undefined: the result is forwarded unmodified.
- Latency is identical in both builds.

## Structure
- pkg_parameters holds:
  - the state enum typedef;
  - the constant RESULT_TIMEOUT_CYCLES=4;
  - the constant TIMEOUT_RESULT = all-ones.
- One sub-module, window_addr_gen, provides the i/j counters, the row-stride accumulator and both address outputs, plus a last-element flag.

## Test plan
- All fin=1, all kernel=2, bias=5, K=3, with a behavioural MAC model -> valid high for exactly 10 contiguous cycles, first beat operands 0, res_data_o=23 at cycle 13.
- fin=0xFF (−1), kernel=3, bias=0 -> res_data_o=0xFFFFFFE5; with MAC_OPERAND_STREAMER_RELU_EN -> 0.
- Window origin row=2, col=25, FIN_WIDTH=28 -> fin addresses 81,82,83,109,110,111,137,138,139 in that order; ker addresses 0..8.
- res_ready_i low for 10 cycles after res_valid_o -> res_data_o stable; busy_o=1; a start_i pulse during this time is ignored.
- MAC model never asserts mac_valid_i -> err_o=1 and res_data_o=0xFFFFFFFF four cycles after WAIT_RES entry; the next start clears err_o.
- rst_i asserted in the 5th FETCH cycle -> all outputs 0 asynchronously; the next start produces the correct result.

Source files
------------

// File: rtl/mac_operand_streamer_pkg.sv
// Shared types and constants for mac_operand_streamer: FSM state encoding
// and the result-timeout behaviour.
package pkg_parameters;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    FETCH,
    DRAIN,
    TERM,
    WAIT_RES,
    OUT
  } state_e;

  localparam int RESULT_TIMEOUT_CYCLES = 4;

  // Sliced down to the result width by the user.
  localparam logic [63:0] TIMEOUT_RESULT = '1;

endpackage

// File: rtl/mac_operand_streamer_window_addr_gen.sv
// Window address generator: j-inner/i-outer counters, feature-map row-stride
// accumulator, kernel address counter and last-element flag.
module window_addr_gen #(
  parameter int KERNEL_SIZE = 3,
  parameter int FIN_WIDTH   = 28,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] win_row_i,
  input  logic [ADDR_WIDTH-1:0] win_col_i,
  output logic [ADDR_WIDTH-1:0] fin_addr_o,
  output logic [ADDR_WIDTH-1:0] ker_addr_o,
  output logic                  last_o
);

  localparam int IW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [IW-1:0]         K_LAST = IW'(KERNEL_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(FIN_WIDTH);

  logic [IW-1:0]         i_q, j_q;
  logic [ADDR_WIDTH-1:0] row_base_q, col_q, ker_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      i_q        <= '0;
      j_q        <= '0;
      row_base_q <= '0;
      col_q      <= '0;
      ker_q      <= '0;
    end else if (load_i) begin
      i_q        <= '0;
      j_q        <= '0;
      // Constant multiply once per window; rows after that only add the stride.
      row_base_q <= win_row_i * STRIDE;
      col_q      <= win_col_i;
      ker_q      <= '0;
    end else if (step_i) begin
      ker_q <= ker_q + ADDR_WIDTH'(1);
      if (j_q == K_LAST) begin
        j_q        <= '0;
        i_q        <= i_q + IW'(1);
        row_base_q <= row_base_q + STRIDE;
      end else begin
        j_q <= j_q + IW'(1);
      end
    end
  end

  assign fin_addr_o = row_base_q + col_q + ADDR_WIDTH'(j_q);
  assign ker_addr_o = ker_q;
  assign last_o     = (i_q == K_LAST) && (j_q == K_LAST);

endmodule

// File: rtl/mac_operand_streamer.sv
// Streams one KxK window of feature map and kernel into a MAC, terminates the
// burst with the bias and returns the MAC result. MAC_OPERAND_STREAMER_RELU_EN clamps negatives.
module mac_operand_streamer
  import pkg_parameters::*;
#(
  parameter int INPUT_BIT_RESOLUTION  = 8,
  parameter int OUTPUT_BIT_RESOLUTION = 32,
  parameter int KERNEL_SIZE           = 3,
  parameter int FIN_WIDTH             = 28,
  parameter int ADDR_WIDTH            = 10
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [ADDR_WIDTH-1:0]            win_row_i,
  input  logic [ADDR_WIDTH-1:0]            win_col_i,
  output logic                             busy_o,
  output logic                             err_o,
  output logic [ADDR_WIDTH-1:0]            fin_addr_o,
  output logic                             fin_en_o,
  input  logic [INPUT_BIT_RESOLUTION-1:0]  fin_rdata_i,
  output logic [ADDR_WIDTH-1:0]            ker_addr_o,
  output logic                             ker_en_o,
  input  logic [INPUT_BIT_RESOLUTION-1:0]  ker_rdata_i,
  input  logic [OUTPUT_BIT_RESOLUTION-1:0] bias_i,
  output logic                             mac_fin_and_kernel_valid_o,
  output logic [INPUT_BIT_RESOLUTION-1:0]  mac_fin_data_o,
  output logic [INPUT_BIT_RESOLUTION-1:0]  mac_kernel_data_o,
  output logic [OUTPUT_BIT_RESOLUTION-1:0] mac_kernel_bias_o,
  input  logic                             mac_valid_i,
  input  logic [OUTPUT_BIT_RESOLUTION-1:0] mac_data_i,
  output logic                             mac_ready_o,
  output logic                             res_valid_o,
  output logic [OUTPUT_BIT_RESOLUTION-1:0] res_data_o,
  input  logic                             res_ready_i
);

  localparam int TO_W = $clog2(RESULT_TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RESULT_TIMEOUT_CYCLES - 1);

  state_e state_q, state_d;

  logic                             start_acc, rd_issue, op_valid, bias_en, ready;
  logic                             rd_vld_q, last, to_hit;
  logic [TO_W-1:0]                  to_cnt_q;
  logic [OUTPUT_BIT_RESOLUTION-1:0] bias_q, res_q, res_in;
  logic                             err_q;
  logic [ADDR_WIDTH-1:0]            fin_addr, ker_addr;

  assign start_acc = (state_q == IDLE) && start_i;
  assign to_hit    = (state_q == WAIT_RES) && !mac_valid_i && (to_cnt_q == TO_LAST);

  window_addr_gen #(
    .KERNEL_SIZE (KERNEL_SIZE),
    .FIN_WIDTH   (FIN_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_addr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (start_acc),
    .step_i     (rd_issue),
    .win_row_i  (win_row_i),
    .win_col_i  (win_col_i),
    .fin_addr_o (fin_addr),
    .ker_addr_o (ker_addr),
    .last_o     (last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    rd_issue = 1'b0;
    op_valid = 1'b0;
    bias_en  = 1'b0;
    ready    = 1'b0;
    case (state_q)
      IDLE:     if (start_i) state_d = PRIME;
      // Element (0,0) is read here so its data lands on the second beat.
      PRIME: begin
        rd_issue = 1'b1;
        op_valid = 1'b1;
        bias_en  = 1'b1;
        state_d  = last ? DRAIN : FETCH;
      end
      FETCH: begin
        rd_issue = 1'b1;
        op_valid = 1'b1;
        bias_en  = 1'b1;
        if (last) state_d = DRAIN;
      end
      DRAIN: begin
        op_valid = 1'b1;
        bias_en  = 1'b1;
        state_d  = TERM;
      end
      TERM: begin
        bias_en = 1'b1;
        ready   = 1'b1;
        state_d = WAIT_RES;
      end
      WAIT_RES: begin
        bias_en = 1'b1;
        ready   = 1'b1;
        if (mac_valid_i || to_hit) state_d = OUT;
      end
      OUT:      if (res_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

`ifdef MAC_OPERAND_STREAMER_RELU_EN
  assign res_in = mac_data_i[OUTPUT_BIT_RESOLUTION-1] ? '0 : mac_data_i;
`else
  assign res_in = mac_data_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_vld_q <= 1'b0;
      bias_q   <= '0;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
      res_q    <= '0;
    end else begin
      rd_vld_q <= rd_issue;
      to_cnt_q <= (state_q == WAIT_RES) ? to_cnt_q + TO_W'(1) : '0;
      if (start_acc) begin
        bias_q <= bias_i;
        err_q  <= 1'b0;
      end
      if (state_q == WAIT_RES) begin
        if (mac_valid_i) begin
          res_q <= res_in;
        end else if (to_hit) begin
          res_q <= TIMEOUT_RESULT[OUTPUT_BIT_RESOLUTION-1:0];
          err_q <= 1'b1;
        end
      end
    end
  end

  // Read data is only meaningful the cycle after a read; otherwise drive zeros.
  assign mac_fin_data_o             = rd_vld_q ? fin_rdata_i : '0;
  assign mac_kernel_data_o          = rd_vld_q ? ker_rdata_i : '0;
  assign mac_fin_and_kernel_valid_o = op_valid;
  assign mac_kernel_bias_o          = bias_en ? bias_q : '0;
  assign mac_ready_o                = ready;

  assign fin_en_o   = rd_issue;
  assign ker_en_o   = rd_issue;
  assign fin_addr_o = rd_issue ? fin_addr : '0;
  assign ker_addr_o = rd_issue ? ker_addr : '0;

  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;
  assign res_valid_o = (state_q == OUT);
  assign res_data_o  = res_q;

endmodule

// File: tb/tb_mac_operand_streamer.sv
// Directed bench for mac_operand_streamer with behavioural memories and MAC.
module tb_mac_operand_streamer;

  localparam int IW = 8, OW = 32, K = 3, FW = 28, AW = 10;

  logic          clk = 1'b0, rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] win_row = '0, win_col = '0;
  logic          busy, err;
  logic [AW-1:0] fin_addr, ker_addr;
  logic          fin_en, ker_en;
  logic [IW-1:0] fin_rdata = '0, ker_rdata = '0;
  logic [OW-1:0] bias = '0;
  logic          op_vld;
  logic [IW-1:0] op_fin, op_ker;
  logic [OW-1:0] op_bias;
  logic          mac_valid = 1'b0;
  logic [OW-1:0] mac_data = '0;
  logic          mac_ready;
  logic          res_valid;
  logic [OW-1:0] res_data;
  logic          res_ready = 1'b1;

  int n_chk = 0, n_fail = 0;
  bit mac_en = 1'b1;

  logic [7:0] fin_mem [0:1023];
  logic [7:0] ker_mem [0:1023];

  always #5 clk = ~clk;

  mac_operand_streamer #(
    .INPUT_BIT_RESOLUTION (IW), .OUTPUT_BIT_RESOLUTION (OW),
    .KERNEL_SIZE (K), .FIN_WIDTH (FW), .ADDR_WIDTH (AW)
  ) dut (
    .clk_i (clk), .rst_i (rst), .start_i (start),
    .win_row_i (win_row), .win_col_i (win_col),
    .busy_o (busy), .err_o (err),
    .fin_addr_o (fin_addr), .fin_en_o (fin_en), .fin_rdata_i (fin_rdata),
    .ker_addr_o (ker_addr), .ker_en_o (ker_en), .ker_rdata_i (ker_rdata),
    .bias_i (bias),
    .mac_fin_and_kernel_valid_o (op_vld),
    .mac_fin_data_o (op_fin), .mac_kernel_data_o (op_ker),
    .mac_kernel_bias_o (op_bias),
    .mac_valid_i (mac_valid), .mac_data_i (mac_data), .mac_ready_o (mac_ready),
    .res_valid_o (res_valid), .res_data_o (res_data), .res_ready_i (res_ready)
  );

  // Synchronous-read memories, one cycle latency.
  always @(posedge clk) begin
    if (fin_en) fin_rdata <= fin_mem[fin_addr];
    if (ker_en) ker_rdata <= ker_mem[ker_addr];
  end

  // Behavioural MAC: drops the first beat, accumulates, adds bias when valid falls.
  int  acc;
  bit  inb;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 0; inb <= 1'b0; mac_valid <= 1'b0; mac_data <= '0;
    end else begin
      if (mac_valid && mac_ready) mac_valid <= 1'b0;
      if (op_vld) begin
        if (!inb) begin inb <= 1'b1; acc <= 0; end
        else acc <= acc + int'($signed(op_fin)) * int'($signed(op_ker));
      end else if (inb) begin
        inb       <= 1'b0;
        mac_data  <= OW'(acc + int'($signed(op_bias)));
        mac_valid <= mac_en;
      end
    end
  end

  typedef struct {
    logic [7:0]  fin, ker;
    logic [31:0] bias;
    logic [9:0]  row, col;
    bit          ramp, mac_en;
    logic [31:0] exp;
    int          exp_cyc;
    bit          exp_err;
  } vec_t;

  vec_t tab [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit outs_zero();
    return ~|{busy, err, fin_addr, fin_en, ker_addr, ker_en, op_vld, op_fin, op_ker,
              op_bias, mac_ready, res_valid, res_data};
  endfunction

  task automatic load_mems(input vec_t v);
    for (int a = 0; a < 1024; a++) begin
      fin_mem[a] = v.ramp ? 8'(a % 64) : v.fin;
      ker_mem[a] = v.ramp ? 8'(a + 1)  : v.ker;
    end
    mac_en = v.mac_en;
  endtask

  // Called at a negedge; start is accepted at the following posedge (cycle 0).
  // Returns at the negedge of the cycle where res_valid is first seen.
  task automatic run_win(input vec_t v, input string tag);
    int c, rc, na;
    bit vld_ok, busy_ok, addr_ok;
    load_mems(v);
    start = 1'b1; win_row = v.row; win_col = v.col; bias = v.bias;
    @(negedge clk);
    start = 1'b0; bias = 32'hDEAD_BEEF; win_row = '0; win_col = '0;
    c = 1; rc = -1; na = 0; vld_ok = 1'b1; busy_ok = 1'b1; addr_ok = 1'b1;
    chk({tag, " err clear"}, err, 0);
    chk({tag, " prime beat"}, {op_vld, op_fin, op_ker}, {1'b1, 16'h0});
    while (c < 40) begin
      if (res_valid) begin rc = c; break; end
      if (op_vld !== ((c >= 1) && (c <= K*K + 1))) vld_ok = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (fin_en) begin
        if (na >= K*K || !ker_en ||
            fin_addr !== 10'((v.row + na / K) * FW + v.col + na % K) ||
            ker_addr !== 10'(na)) addr_ok = 1'b0;
        na++;
      end
      if (c == K*K + 2) chk({tag, " term bias"}, {op_vld, mac_ready, op_bias}, {2'b01, v.bias});
      @(negedge clk);
      c++;
    end
    chk({tag, " valid burst"}, vld_ok, 1);
    chk({tag, " busy"}, busy_ok, 1);
    chk({tag, " addr seq"}, {addr_ok, 8'(na)}, {1'b1, 8'(K*K)});
    chk({tag, " res cycle"}, 64'(rc), 64'(v.exp_cyc));
    chk({tag, " res data"}, res_data, v.exp);
    chk({tag, " err"}, err, v.exp_err);
  endtask

  initial begin
    bit ok;
    logic [31:0] neg_exp1, neg_exp3, neg_exp5;
`ifdef MAC_OPERAND_STREAMER_RELU_EN
    neg_exp1 = 32'h0; neg_exp3 = 32'h0; neg_exp5 = 32'h0;
`else
    neg_exp1 = 32'hFFFF_FFE5; neg_exp3 = 32'hFFFD_C4E4; neg_exp5 = 32'hFFFF_FFF8;
`endif
    //          fin    ker    bias        row    col    ramp mac  exp                cyc err
    tab[0] = '{8'h01, 8'h02, 32'd5,       10'd0, 10'd0, 0, 1, 32'd23,             13, 0};
    tab[1] = '{8'hFF, 8'h03, 32'd0,       10'd4, 10'd7, 0, 1, neg_exp1,           13, 0};
    tab[2] = '{8'h00, 8'h00, 32'd6,       10'd2, 10'd25, 1, 1, 32'd1050,          13, 0};
    tab[3] = '{8'h7F, 8'h80, 32'd100,     10'd10, 10'd3, 0, 1, neg_exp3,          13, 0};
    tab[4] = '{8'h01, 8'h01, 32'd0,       10'd1, 10'd1, 0, 0, 32'hFFFF_FFFF,      16, 1};
    tab[5] = '{8'h02, 8'hFF, 32'd10,      10'd36, 10'd20, 0, 1, neg_exp5,         13, 0};

    repeat (2) @(negedge clk);
    chk("reset outputs", outs_zero(), 1);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back windows with res_ready held high: next start the cycle after handshake.
    for (int n = 0; n < 6; n++) begin
      run_win(tab[n], $sformatf("vec%0d", n));
      @(negedge clk);
      chk($sformatf("vec%0d idle after hs", n), {busy, res_valid}, 2'b00);
    end

    // Result held while downstream stalls; a start in this window is ignored.
    res_ready = 1'b0;
    run_win(tab[0], "stall");
    ok = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = (k == 3); win_row = 10'd5; bias = 32'd77;
      if (!res_valid || !busy || res_data !== 32'd23 || op_vld || fin_en) ok = 1'b0;
    end
    start = 1'b0;
    chk("stall hold", ok, 1);
    res_ready = 1'b1;
    @(negedge clk);
    chk("stall release", {busy, res_valid}, 2'b00);
    run_win(tab[2], "after stall");
    @(negedge clk);

    // Asynchronous reset in the 5th FETCH cycle, then a clean window.
    load_mems(tab[0]);
    start = 1'b1; bias = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid-burst state", {op_vld, fin_en, busy}, 3'b111);
    rst = 1'b1;
    #1;
    chk("async reset outs", outs_zero(), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_win(tab[0], "post reset");
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
